// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the default access timeout.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality/alignment of the incoming op, store
// byte-enable and lane replication, and load extraction with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_load,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic        req_legal,
  output logic        req_aligned,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] w;
    w = v;
    return w;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] w;
    w = v;
    return w;
  endfunction

  logic [31:0] shifted;

  always_comb begin
    req_legal = 1'b0;
    if (is_load) begin
      case (req_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: req_legal = 1'b1;
        default:                        req_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        F3_B, F3_H, F3_W: req_legal = 1'b1;
        default:          req_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    req_aligned = 1'b0;
    st_be       = 4'b0000;
    st_wdata    = '0;
    case (req_funct3[1:0])
      2'b00: begin
        req_aligned = 1'b1;
        st_be       = 4'b0001 << req_off;
        st_wdata    = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_aligned = ~req_off[0];
        st_be       = req_off[1] ? 4'b1100 : 4'b0011;
        st_wdata    = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_aligned = (req_off == 2'b00);
        st_be       = 4'b1111;
        st_wdata    = req_wdata;
      end
      default: begin
        req_aligned = 1'b0;
      end
    endcase
  end

  // Bring the addressed byte/halfword down to lane 0 before extending.
  assign shifted = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = ld_rdata;
    case (ld_funct3)
      F3_B:    ld_data = sext8(shifted[7:0]);
      F3_H:    ld_data = sext16(shifted[15:0]);
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_HU:   ld_data = {16'd0, shifted[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// Load/store unit: req/gnt/rvalid handshake to data memory, core stall while
// an access is in flight, and register-file writeback for loads.
module lsu_wb
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        lsu_fault
);

  lsu_state_e       state;
  logic             load_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timeout_q;
  logic             limit;

  logic             legal;
  logic             aligned;
  logic             accept;
  logic             reject;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

  lsu_align u_align (
    .is_load     (ex_load),
    .req_funct3  (ex_funct3),
    .req_off     (ex_addr[1:0]),
    .req_wdata   (ex_wdata),
    .req_legal   (legal),
    .req_aligned (aligned),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_funct3   (f3_q),
    .ld_off      (off_q),
    .ld_rdata    (mem_rdata),
    .ld_data     (ld_data)
  );

  assign accept    = (state == ST_IDLE) & ex_valid & (ex_load ^ ex_store) & legal & aligned;
  assign reject    = (state == ST_IDLE) & ex_valid & (ex_load | ex_store) & ~accept;
  assign stall     = accept | (state == ST_REQ) | (state == ST_WAIT);
  assign lsu_fault = reject | ((state == ST_DONE) & timeout_q);
  assign cnt_nxt   = cnt_q + CNT_W'(1);
  assign limit     = (cnt_nxt == CNT_W'(TIMEOUT));

  // A completing handshake beats the timeout in the same cycle; a load grant
  // at the limit is abandoned because no rvalid could follow in budget.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      load_q    <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      wb_we <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          timeout_q <= 1'b0;
          if (accept) begin
            load_q    <= ex_load;
            f3_q      <= ex_funct3;
            off_q     <= ex_addr[1:0];
            mem_addr  <= {ex_addr[31:2], 2'b00};
            mem_we    <= ex_store;
            mem_be    <= st_be;
            mem_wdata <= st_wdata;
            wb_addr   <= ex_rd;
            cnt_q     <= '0;
            mem_req   <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_nxt;
          if (mem_gnt && !load_q) begin
            mem_req <= 1'b0;
            state   <= ST_DONE;
          end else if (limit) begin
            mem_req   <= 1'b0;
            timeout_q <= 1'b1;
            state     <= ST_DONE;
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_nxt;
          if (mem_rvalid) begin
            wb_data <= ld_data;
            wb_we   <= (wb_addr != 5'd0);
            state   <= ST_DONE;
          end else if (limit) begin
            timeout_q <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          timeout_q <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb.sv
// Randomized and directed bench for lsu_wb against a byte-level reference
// model of the load/store rules and handshake timing.
module tb_lsu_wb;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic        wb_we, lsu_fault;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_wb #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .lsu_fault(lsu_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model ----
  function automatic bit m_legal(input bit ld, input bit st, input logic [2:0] f3);
    if (ld == st) return 1'b0;
    if (ld) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    return f3 inside {3'd0, 3'd1, 3'd2};
  endfunction

  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n = m_size(f3);
    int off = int'(a % 4);
    logic [3:0] be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    int n = m_size(f3);
    logic [31:0] wd = '0;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % n) +: 8];
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int n = m_size(f3);
    int off = int'(a % 4);
    longint unsigned u = rd;
    longint v;
    v = longint'((u >> (8*off)) & ((64'd1 << (8*n)) - 64'd1));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  // One instruction presented in an IDLE cycle, then the memory side is played
  // out: grant on REQ cycle gnt_at (0 = never), rvalid on WAIT cycle rv_at.
  task automatic do_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input int gnt_at, input int rv_at, input logic [31:0] rdat);
    bit acc, to, done, in_wait, exp_we;
    int tcnt, w, stalls, wbs;
    acc = m_legal(ld, st, f3) && ((a % m_size(f3)) == 0);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd; ex_rd = rd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk({tag, "_acc_stall"}, stall, acc);
    chk({tag, "_acc_fault"}, lsu_fault, !acc && (ld || st));
    chk({tag, "_acc_req"}, mem_req, 0);
    stalls = int'(stall);
    wbs = 0;
    tick();
    ex_valid = 1'b0;
    if (!acc) begin
      #1;
      chk({tag, "_rej_req"}, mem_req, 0);
      chk({tag, "_rej_stall"}, stall, 0);
      chk({tag, "_rej_we"}, wb_we, 0);
      return;
    end
    tcnt = 0; w = 0; done = 0; in_wait = 0; to = 0;
    while (!done && tcnt < TMO + 4) begin
      tcnt++;
      if (!in_wait) begin
        mem_gnt = (tcnt == gnt_at);
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        chk({tag, "_req"}, mem_req, 1);
        chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_we"}, mem_we, st);
        if (st) begin
          chk({tag, "_be"}, mem_be, m_be(f3, a));
          chk({tag, "_wdata"}, mem_wdata, m_wd(f3, wd));
        end
        chk({tag, "_req_fault"}, lsu_fault, 0);
        stalls += int'(stall);
        wbs += int'(wb_we);
        tick();
        if (mem_gnt && st) done = 1;
        else if (tcnt == TMO) begin done = 1; to = 1; end
        else if (mem_gnt) in_wait = 1;
      end else begin
        w++;
        mem_gnt = 1'b0;
        mem_rvalid = (w == rv_at);
        mem_rdata = mem_rvalid ? rdat : $urandom;
        #1;
        chk({tag, "_wait_req"}, mem_req, 0);
        chk({tag, "_wait_fault"}, lsu_fault, 0);
        stalls += int'(stall);
        wbs += int'(wb_we);
        tick();
        if (mem_rvalid) done = 1;
        else if (tcnt == TMO) begin done = 1; to = 1; end
      end
    end
    chk({tag, "_bound"}, done, 1);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    exp_we = ld && !to && (rd != 5'd0);
    chk({tag, "_done_stall"}, stall, 0);
    chk({tag, "_done_req"}, mem_req, 0);
    chk({tag, "_done_we"}, wb_we, exp_we);
    chk({tag, "_done_fault"}, lsu_fault, to);
    if (exp_we) begin
      chk({tag, "_wb_addr"}, wb_addr, rd);
      chk({tag, "_wb_data"}, wb_data, m_ld(f3, a, rdat));
    end
    wbs += int'(wb_we);
    tick();
    #1;
    chk({tag, "_idle_fault"}, lsu_fault, 0);
    chk({tag, "_idle_stall"}, stall, 0);
    wbs += int'(wb_we);
    chk({tag, "_stall_cycles"}, stalls, 1 + tcnt);
    chk({tag, "_wb_cycles"}, wbs, exp_we);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = '0;
    ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #2 reset = 1'b1;
    tick(); tick();
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_fault", lsu_fault, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    reset = 1'b0;

    do_op("sw",    0, 1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 2, 0, 32'h0);
    do_op("lb",    1, 0, 3'b000, 32'h0000_0203, 32'h0, 5'd5, 1, 1, 32'h8012_3456);
    do_op("lbu",   1, 0, 3'b100, 32'h0000_0203, 32'h0, 5'd5, 1, 1, 32'h8012_3456);
    do_op("sh",    0, 1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd0, 1, 0, 32'h0);
    do_op("lw_mis", 1, 0, 3'b010, 32'h0000_0101, 32'h0, 5'd3, 1, 1, 32'h0);
    do_op("ld_f3", 1, 0, 3'b011, 32'h0000_0100, 32'h0, 5'd3, 1, 1, 32'h0);
    do_op("ldst",  1, 1, 3'b010, 32'h0000_0100, 32'h0, 5'd3, 1, 1, 32'h0);
    do_op("lw_to", 1, 0, 3'b010, 32'h0000_0300, 32'h0, 5'd9, 0, 0, 32'h0);
    do_op("lw_wto", 1, 0, 3'b010, 32'h0000_0304, 32'h0, 5'd9, 1, 0, 32'h0);
    do_op("lh_r0", 1, 0, 3'b001, 32'h0000_0306, 32'h0, 5'd0, 1, 2, 32'h8001_7FFF);

    // Reset while a load sits in WAIT, then a late rvalid.
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b001;
    ex_addr = 32'h0000_0402; ex_rd = 5'd7;
    tick();
    ex_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("rstw_pre_stall", stall, 1);
    reset = 1'b1;
    #1;
    chk("rstw_req", mem_req, 0);
    chk("rstw_stall", stall, 0);
    chk("rstw_we", wb_we, 0);
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    repeat (3) begin
      #1;
      chk("rstw_late_we", wb_we, 0);
      chk("rstw_late_stall", stall, 0);
      tick();
    end
    mem_rvalid = 1'b0;

    // Reset while a store request is waiting for its grant.
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b1; ex_funct3 = 3'b010;
    ex_addr = 32'h0000_0500; ex_wdata = 32'h5555_AAAA;
    tick();
    ex_valid = 1'b0;
    #1;
    chk("rstr_pre_req", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("rstr_req", mem_req, 0);
    chk("rstr_stall", stall, 0);
    tick();
    reset = 1'b0;

    for (int k = 0; k < 40; k++) begin
      int r;
      bit ld, st;
      r = $urandom_range(0, 9);
      ld = (r == 1) || (r >= 2 && r < 6);
      st = (r == 1) || (r >= 6);
      do_op("rnd", ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom,
            5'($urandom_range(0, 31)), $urandom_range(1, 4), $urandom_range(1, 4), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
